// File: rtl/uart_tx.sv
// uart_tx -- 8-bit UART transmitter, start bit, 8 data bits LSB first, one stop bit.
// Every bit is held for CLKS_PER_BIT clock cycles. Define UART_TX_PARITY_EN to
// insert an even-parity bit between the last data bit and the stop bit.
// All outputs come straight from registers; reset is synchronous, active-high.

module uart_tx #(
  parameter int CLKS_PER_BIT = 25
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  // Bit timer counts 0 .. CLKS_PER_BIT-1 inside each serial bit.
  localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TIMER_ZERO = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            bit_end_s;

`ifdef UART_TX_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    even_parity = ^data;
  endfunction
`endif

  assign bit_end_s = (timer_q == TIMER_LAST);

  // Register all state and outputs; reset wins over any request on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= TIMER_ZERO;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        timer_d   = TIMER_ZERO;
        bit_idx_d = 3'd0;
        if (tx_start) begin
          // Byte is captured only here; it stays frozen for the whole frame.
          shift_d = tx_data;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end else begin
          shift_d = shift_q;
          state_d = IDLE;
        end
      end

      START: begin
        if (bit_end_s) begin
          timer_d   = TIMER_ZERO;
          bit_idx_d = 3'd0;
          state_d   = DATA;
          tx_d      = shift_q[0];
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      DATA: begin
        if (bit_end_s) begin
          timer_d = TIMER_ZERO;
          // Index wraps 7 -> 0 when the last data bit has been sent.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = even_parity(shift_q);
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            state_d = DATA;
            tx_d    = shift_q[bit_idx_q + 3'd1];
          end
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_s) begin
          timer_d = TIMER_ZERO;
          state_d = STOP;
          tx_d    = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end
`endif

      STOP: begin
        if (bit_end_s) begin
          // Frame complete: back to idle with a single-cycle done pulse.
          timer_d = TIMER_ZERO;
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_ONE;
        end
      end

      default: begin
        state_d   = IDLE;
        timer_d   = TIMER_ZERO;
        bit_idx_d = 3'd0;
        tx_d      = 1'b1;
        busy_d    = 1'b0;
        done_d    = 1'b0;
      end
    endcase
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx -- directed checks of uart_tx at CLKS_PER_BIT=4 and the default 25.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       start4, start25;
  logic [7:0] data4, data25;
  logic       tx4, busy4, done4;
  logic       tx25, busy25, done25;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .reset(reset), .tx_start(start4), .tx_data(data4),
    .tx(tx4), .busy(busy4), .done(done4)
  );

  uart_tx dut25 (
    .clk(clk), .reset(reset), .tx_start(start25), .tx_data(data25),
    .tx(tx25), .busy(busy25), .done(done25)
  );

  // Frame bits in transmit order: bit 0 is the start bit.
  function automatic logic [10:0] mk(input logic [7:0] d, input logic p);
`ifdef UART_TX_PARITY_EN
    mk = {1'b1, p, d, 1'b0};
`else
    mk = {p & 1'b0, 1'b1, d, 1'b0};
`endif
  endfunction

  // Called on the falling edge right after the accepting edge; returns on the done cycle.
  task automatic check_frame(input bit sel, input logic [10:0] fr, input string name);
    int cpb;
    logic t, b, d;
    cpb = sel ? 25 : 4;
    for (int k = 0; k < NB * cpb; k++) begin
      t = sel ? tx25 : tx4;
      b = sel ? busy25 : busy4;
      d = sel ? done25 : done4;
      total++;
      if (t !== fr[k / cpb]) begin
        bad++;
        $display("FAIL %s tx cycle %0d: got %b want %b", name, k, t, fr[k / cpb]);
      end
      total++;
      if (b !== 1'b1) begin
        bad++;
        $display("FAIL %s busy cycle %0d: got %b want 1", name, k, b);
      end
      total++;
      if (d !== 1'b0) begin
        bad++;
        $display("FAIL %s done-early cycle %0d: got %b want 0", name, k, d);
      end
      @(negedge clk);
    end
    t = sel ? tx25 : tx4;
    b = sel ? busy25 : busy4;
    d = sel ? done25 : done4;
    total++;
    if (t !== 1'b1) begin bad++; $display("FAIL %s end tx: got %b want 1", name, t); end
    total++;
    if (b !== 1'b0) begin bad++; $display("FAIL %s end busy: got %b want 0", name, b); end
    total++;
    if (d !== 1'b1) begin bad++; $display("FAIL %s done pulse: got %b want 1", name, d); end
  endtask

  task automatic start_frame(input bit sel, input logic [7:0] d);
    if (sel) begin start25 = 1'b1; data25 = d; end
    else begin start4 = 1'b1; data4 = d; end
    @(negedge clk);
    start4  = 1'b0;
    start25 = 1'b0;
  endtask

  task automatic check_idle4(input string name);
    total++;
    if (tx4 !== 1'b1) begin bad++; $display("FAIL %s tx: got %b want 1", name, tx4); end
    total++;
    if (busy4 !== 1'b0) begin bad++; $display("FAIL %s busy: got %b want 0", name, busy4); end
    total++;
    if (done4 !== 1'b0) begin bad++; $display("FAIL %s done: got %b want 0", name, done4); end
  endtask

  task automatic test_reset;
    reset = 1'b1; start4 = 1'b0; start25 = 1'b0; data4 = 8'h00; data25 = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle4("reset_state4");
    total++;
    if ({tx25, busy25, done25} !== 3'b100) begin
      bad++; $display("FAIL reset_state25: got %b want 100", {tx25, busy25, done25});
    end
    @(negedge clk);
    check_idle4("reset_idle4");
  endtask

  task automatic test_a5;
    start_frame(1'b0, 8'hA5);
    check_frame(1'b0, mk(8'hA5, 1'b0), "a5");
    @(negedge clk);
    check_idle4("a5_after_done");
  endtask

  task automatic test_back_to_back;
    start4 = 1'b1; data4 = 8'hA5;
    @(negedge clk);
    data4 = 8'h3C;                     // start stays high throughout the first frame
    check_frame(1'b0, mk(8'hA5, 1'b0), "hold_first");
    @(negedge clk);                    // second frame accepted on the done cycle
    start4 = 1'b0;
    check_frame(1'b0, mk(8'h3C, 1'b0), "hold_second");
    @(negedge clk);
    check_idle4("hold_after_done");
  endtask

  task automatic test_reset_mid_frame;
    start_frame(1'b0, 8'hA5);
    repeat (4 * 4 + 1) @(negedge clk); // inside frame bit 4
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle4("abort_now");
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      total++;
      if ({busy4, done4} !== 2'b00) begin
        bad++; $display("FAIL abort_quiet cycle %0d: busy,done got %b want 00", k, {busy4, done4});
      end
    end
  endtask

  task automatic test_reset_vs_start;
    reset = 1'b1; start4 = 1'b1; data4 = 8'hFF;
    @(negedge clk);
    reset = 1'b0; start4 = 1'b0;
    check_idle4("rst_start_now");
    @(negedge clk);
    check_idle4("rst_start_next");
  endtask

  task automatic test_start_after_reset;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start_frame(1'b0, 8'h5A);
    check_frame(1'b0, mk(8'h5A, 1'b0), "post_reset_5a");
    @(negedge clk);
  endtask

  task automatic test_parity;
    start_frame(1'b0, 8'h07);
    check_frame(1'b0, mk(8'h07, 1'b1), "par_07");
    @(negedge clk);
    start_frame(1'b0, 8'h03);
    check_frame(1'b0, mk(8'h03, 1'b0), "par_03");
    @(negedge clk);
  endtask

  task automatic test_wide;
    start_frame(1'b1, 8'h00);
    check_frame(1'b1, mk(8'h00, 1'b0), "w25_00");
    @(negedge clk);
    start_frame(1'b1, 8'hFF);
    check_frame(1'b1, mk(8'hFF, 1'b0), "w25_ff");
    @(negedge clk);
    total++;
    if ({tx25, busy25, done25} !== 3'b100) begin
      bad++; $display("FAIL w25_idle: got %b want 100", {tx25, busy25, done25});
    end
  endtask

  initial begin
    reset = 1'b1;
    start4 = 1'b0; start25 = 1'b0; data4 = 8'h00; data25 = 8'h00;
    @(negedge clk);
    test_reset();
    test_a5();
    test_back_to_back();
    test_reset_mid_frame();
    test_reset_vs_start();
    test_start_after_reset();
    test_parity();
    test_wide();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
